// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 2:1 mux arbiter: FSM state encodings
// and default sizing constants.
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_BURST  = 4;
    localparam int DEF_CNT_W  = 6;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the downstream
// consumer; master drives requests and downstream ready, slave is the arbiter.
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 2,
    parameter int CNT_W  = 6
);
    logic              valid0;
    logic [DATA_W-1:0] data_in0;
    logic              ready0;
    logic              valid1;
    logic [DATA_W-1:0] data_in1;
    logic              ready1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_out;
    logic              selector;
    logic [CNT_W-1:0]  contador;

    modport master (
        output valid0, data_in0, valid1, data_in1, ready_out,
        input  ready0, ready1, data_out, valid_out, selector, contador
    );

    modport slave (
        input  valid0, data_in0, valid1, data_in1, ready_out,
        output ready0, ready1, data_out, valid_out, selector, contador
    );
endinterface

// File: rtl/mux_rr_arbiter_out_stage_reg.sv
// Registered output word with valid/ready: loads on an accepted transfer,
// holds under backpressure, clears once the consumer takes the word.
module out_stage_reg #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              pipe_ready
);
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (ready_out) begin
            valid_reg <= 1'b0;
        end
    end

    // The stage can take a new word if it is empty or is being drained now.
    assign pipe_ready = !valid_reg || ready_out;
    assign data_out   = data_reg;
    assign valid_out  = valid_reg;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two valid/ready requesters feeding a 2:1 mux; owns
// the selector, limits each grant to BURST transfers while the other waits.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BURST  = DEF_BURST,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic             clk,
    input logic             reset_L,
    mux_rr_arbiter_if.slave bus
);
    localparam int BC_W = $clog2(BURST + 1);

    state_t            state_reg;
    logic [BC_W-1:0]   burst_cnt_reg;
    logic              last_served_reg;
    logic              selector_reg;
    logic [CNT_W-1:0]  contador_reg;

    logic              pipe_ready;
    logic              serve0;
    logic              serve1;
    logic              cur;
    logic              valid_cur;
    logic              valid_oth;
    logic [DATA_W-1:0] data_cur;
    logic              xfer;
    logic [BC_W-1:0]   burst_cnt_next;
    logic              burst_done;

    always_comb begin
        serve0         = (state_reg == SERVE0);
        serve1         = (state_reg == SERVE1);
        cur            = serve1;
        valid_cur      = serve1 ? bus.valid1   : bus.valid0;
        valid_oth      = serve1 ? bus.valid0   : bus.valid1;
        data_cur       = serve1 ? bus.data_in1 : bus.data_in0;
        xfer           = (serve0 || serve1) && valid_cur && pipe_ready;
        burst_cnt_next = burst_cnt_reg + 1'b1;
        burst_done     = (burst_cnt_next == BC_W'(BURST));
    end

    // Ready depends only on the registered grant, so it never disagrees with selector.
    assign bus.ready0   = serve0 && pipe_ready;
    assign bus.ready1   = serve1 && pipe_ready;
    assign bus.selector = selector_reg;
    assign bus.contador = contador_reg;

    out_stage_reg #(.DATA_W(DATA_W)) u_out_stage (
        .clk        (clk),
        .reset_L    (reset_L),
        .load       (xfer),
        .load_data  (data_cur),
        .ready_out  (bus.ready_out),
        .data_out   (bus.data_out),
        .valid_out  (bus.valid_out),
        .pipe_ready (pipe_ready)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg       <= IDLE;
            burst_cnt_reg   <= '0;
            last_served_reg <= 1'b1;
            selector_reg    <= 1'b0;
            contador_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // On a tie, grant whichever requester was not served last.
                    if (bus.valid0 && (!bus.valid1 || last_served_reg)) begin
                        state_reg     <= SERVE0;
                        selector_reg  <= 1'b0;
                        burst_cnt_reg <= '0;
                    end else if (bus.valid1) begin
                        state_reg     <= SERVE1;
                        selector_reg  <= 1'b1;
                        burst_cnt_reg <= '0;
                    end
                end
                SERVE0, SERVE1: begin
                    if (xfer) begin
                        contador_reg    <= contador_reg + 1'b1;
                        last_served_reg <= cur;
                        if (burst_done) begin
                            burst_cnt_reg <= '0;
                            if (valid_oth) begin
                                state_reg    <= cur ? SERVE0 : SERVE1;
                                selector_reg <= !cur;
                            end
                        end else begin
                            burst_cnt_reg <= burst_cnt_next;
                        end
                    end else if (!valid_cur) begin
                        burst_cnt_reg <= '0;
                        if (valid_oth) begin
                            state_reg    <= cur ? SERVE0 : SERVE1;
                            selector_reg <= !cur;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed phases then random traffic against a
// behavioural round-robin model.
module tb_mux_rr_arbiter;
    localparam int DATA_W = 2;
    localparam int BURST  = 4;
    localparam int CNT_W  = 6;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    mux_rr_arbiter #(.DATA_W(DATA_W), .BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: served = -1 when nobody holds the grant, else the requester index.
    int served, run, last, sel, dout, vout, cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        served = -1; run = 0; last = 1; sel = 0; dout = 0; vout = 0; cnt = 0;
    endtask

    task automatic check_all();
        int pr;
        pr = (vout == 0 || bus.ready_out) ? 1 : 0;
        chk("ready0",    32'(bus.ready0),    32'((served == 0 && pr == 1) ? 1 : 0));
        chk("ready1",    32'(bus.ready1),    32'((served == 1 && pr == 1) ? 1 : 0));
        chk("selector",  32'(bus.selector),  32'(sel));
        chk("valid_out", 32'(bus.valid_out), 32'(vout));
        if (vout != 0 || dout == 0)
            chk("data_out", 32'(bus.data_out), 32'(dout));
        chk("contador",  32'(bus.contador),  32'(cnt));
    endtask

    task automatic model_update();
        int v[2];
        int d[2];
        int pr, pick, x, o, acc;
        pr   = (vout == 0 || bus.ready_out) ? 1 : 0;
        v[0] = int'(bus.valid0);  v[1] = int'(bus.valid1);
        d[0] = int'(bus.data_in0); d[1] = int'(bus.data_in1);
        acc  = 0;
        x    = 0;
        if (served < 0) begin
            pick = -1;
            if (v[0] == 1 && v[1] == 1) pick = 1 - last;
            else if (v[0] == 1)         pick = 0;
            else if (v[1] == 1)         pick = 1;
            if (pick >= 0) begin
                served = pick; run = 0; sel = pick;
            end
        end else begin
            x   = served;
            o   = 1 - x;
            acc = (v[x] == 1 && pr == 1) ? 1 : 0;
            if (acc == 1) begin
                cnt  = (cnt + 1) % (1 << CNT_W);
                run  = run + 1;
                last = x;
                if (run == BURST) begin
                    run = 0;
                    if (v[o] == 1) begin
                        served = o; sel = o;
                    end
                end
            end else if (v[x] == 0) begin
                run = 0;
                if (v[o] == 1) begin
                    served = o; sel = o;
                end else begin
                    served = -1;
                end
            end
        end
        if (acc == 1) begin
            dout = d[x]; vout = 1;
        end else if (vout == 1 && bus.ready_out) begin
            vout = 0;
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic step(input logic v0, input logic [1:0] d0, input logic v1,
                        input logic [1:0] d1, input logic ro);
        bus.valid0 = v0; bus.data_in0 = d0;
        bus.valid1 = v1; bus.data_in1 = d1;
        bus.ready_out = ro;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic async_reset_pulse();
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        bus.valid0 = 1'b0; bus.data_in0 = '0;
        bus.valid1 = 1'b0; bus.data_in1 = '0;
        bus.ready_out = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_L = 1'b1;

        // Idle with nothing requested.
        repeat (3) step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // Fair alternation from reset: requester 0 is granted first.
        repeat (26) step(1'b1, 2'b01, 1'b1, 2'b11, 1'b1);
        repeat (2) step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // Single requester: burst wrap without a switch.
        reset_L = 1'b0;
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        repeat (10) step(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        chk("single_cnt9", 32'(bus.contador), 32'd9);
        chk("single_sel0", 32'(bus.selector), 32'd0);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // Backpressure while requester 1 is served.
        repeat (3) step(1'b0, 2'b00, 1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b1, 2'(i), 1'b0);
        repeat (4) step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        // Early handoff: requester 0 drops after two transfers.
        repeat (3) step(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1);
        chk("handoff_sel1", 32'(bus.selector), 32'd1);
        chk("handoff_rdy1", 32'(bus.ready1), 32'd1);
        repeat (2) step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1);

        // Async reset mid-burst with a word in the output stage.
        async_reset_pulse();
        repeat (6) step(1'b1, 2'b00, 1'b1, 2'b11, 1'b1);

        // Random traffic with occasional backpressure and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end else begin
                step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
